// File: rtl/datapath_pkg.sv
// Shared opcodes, FSM state type and immediate-extension helper for datapath_core.
package datapath_pkg;

    // Instruction encodings
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_ADDI = 4'b0101;
    localparam logic [3:0] OP_LI   = 4'b0110;
    localparam logic [3:0] OP_LW   = 4'b0111;
    localparam logic [3:0] OP_SW   = 4'b1000;
    localparam logic [3:0] OP_MFHI = 4'b1101;
    localparam logic [3:0] OP_MUL  = 4'b1110;
    localparam logic [3:0] OP_MFLO = 4'b1111;

    // Working width of ext_imm; callers cast the result down to their word width
    localparam int unsigned EXT_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    // Zero- or sign-extend the low imm_w bits of raw to EXT_W bits
    function automatic logic [EXT_W-1:0] ext_imm(
        input logic [EXT_W-1:0] raw,
        input int unsigned      imm_w,
        input logic             is_signed
    );
        logic [EXT_W-1:0] r;
        logic             fill;
        fill = is_signed & raw[6'(imm_w - 1)];
        for (int unsigned i = 0; i < EXT_W; i++) begin
            if (i >= imm_w) begin
                r[6'(i)] = fill;
            end else begin
                r[6'(i)] = raw[6'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/datapath_core_mul_seq.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// The first step is folded into the start edge, so the product register
// updates DATA_W-1 edges after start and done pulses in the following cycle.
module mul_seq #(
    parameter int unsigned DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int unsigned PW    = 2 * DATA_W;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [PW-1:0]     mcand;
    logic [DATA_W-1:0] mplier;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     acc_nxt;
    logic [CNT_W-1:0]  cnt;

    // Accumulate the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        acc_nxt = acc + (mplier[0] ? mcand : '0);
    end

    // Step sequencer; product only changes on the final step so no partial value is exposed
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                acc    <= b[0] ? PW'(a) : '0;
                mcand  <= PW'(a) << 1;
                mplier <= b >> 1;
                cnt    <= CNT_W'(DATA_W - 1);
                busy   <= 1'b1;
            end else if (busy) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    product <= acc_nxt;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/datapath_core.sv
// Clocked R/I-type datapath: register file, HI/LO, data memory and an
// iterative multiplier behind a valid/ready instruction handshake.
module datapath_core
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned NREG       = 8,
    parameter int unsigned IMM_W      = 6,
    parameter int unsigned IMM_SIGNED = 0,
    parameter int unsigned MEM_DEPTH  = 16,
    parameter int unsigned SHAMT_W    = $clog2(DATA_W),
    localparam int unsigned REG_AW    = $clog2(NREG),
    localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [3:0]         op_code,
    input  logic [REG_AW-1:0]  rs_idx,
    input  logic [REG_AW-1:0]  rt_idx,
    input  logic [REG_AW-1:0]  rd_idx,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [IMM_W-1:0]   imm,
    input  logic               sel,
    output logic               done,
    output logic [DATA_W-1:0]  result,
    output logic               busy,
    input  logic [REG_AW-1:0]  dbg_idx,
    output logic [DATA_W-1:0]  dbg_data
);

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0]   rf  [NREG];
    logic [DATA_W-1:0]   mem [MEM_DEPTH];

    logic [DATA_W-1:0]   rs_val;
    logic [DATA_W-1:0]   rt_val;
    logic [DATA_W-1:0]   imm_ext;
    logic [DATA_W-1:0]   op_b;
    logic [MEM_AW-1:0]   mem_addr;
    logic                accept;

    logic                wr_en;
    logic [REG_AW-1:0]   wr_idx;
    logic [DATA_W-1:0]   wr_data;
    logic                mem_we;
    logic                done_nxt;
    logic [DATA_W-1:0]   result_nxt;
    logic                mul_start;

    logic                mul_busy;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;

    // Operand fetch and address generation
    assign rs_val      = rf[rs_idx];
    assign rt_val      = rf[rt_idx];
    assign imm_ext     = DATA_W'(ext_imm(EXT_W'(imm), IMM_W, 1'(IMM_SIGNED)));
    assign op_b        = sel ? imm_ext : rt_val;
    assign mem_addr    = MEM_AW'(rs_val + imm_ext);
    assign busy        = (state == MUL);
    assign instr_ready = ~busy;
    assign accept      = instr_valid & instr_ready;
    assign dbg_data    = rf[dbg_idx];

    // The multiplier's product register doubles as {HI,LO}
    mul_seq #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start & ~mul_busy),
        .a       (rs_val),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, instruction decode and commit controls
    always_comb begin
        state_nxt  = state;
        mul_start  = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = rd_idx;
        wr_data    = '0;
        mem_we     = 1'b0;
        done_nxt   = 1'b0;
        result_nxt = result;
        case (state)
            IDLE: begin
                if (accept) begin
                    done_nxt   = 1'b1;
                    result_nxt = '0;
                    case (op_code)
                        OP_ADD:  begin wr_en = 1'b1; wr_data = rs_val + op_b;     end
                        OP_SLL:  begin wr_en = 1'b1; wr_data = rs_val << shamt;   end
                        OP_SRL:  begin wr_en = 1'b1; wr_data = rs_val >> shamt;   end
                        OP_OR:   begin wr_en = 1'b1; wr_data = rs_val | op_b;     end
                        OP_AND:  begin wr_en = 1'b1; wr_data = rs_val & op_b;     end
                        OP_ADDI: begin wr_en = 1'b1; wr_idx = rt_idx; wr_data = rs_val + imm_ext; end
                        OP_LI:   begin wr_en = 1'b1; wr_idx = rt_idx; wr_data = imm_ext;          end
                        OP_LW:   begin wr_en = 1'b1; wr_idx = rt_idx; wr_data = mem[mem_addr];    end
                        OP_SW:   begin mem_we = 1'b1; end
                        OP_MFHI: begin wr_en = 1'b1; wr_data = mul_product[2*DATA_W-1:DATA_W]; end
                        OP_MFLO: begin wr_en = 1'b1; wr_data = mul_product[DATA_W-1:0];        end
                        OP_MUL:  begin
                            done_nxt   = 1'b0;
                            result_nxt = result;
                            mul_start  = 1'b1;
                            state_nxt  = MUL;
                        end
                        default: ;
                    endcase
                    if (wr_en) begin
                        result_nxt = wr_data;
                    end
                    if (mem_we) begin
                        result_nxt = rt_val;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_nxt  = IDLE;
                    done_nxt   = 1'b1;
                    result_nxt = mul_product[DATA_W-1:0];
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Architectural state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
            done   <= 1'b0;
            result <= '0;
        end else begin
            done   <= done_nxt;
            result <= result_nxt;
            if (wr_en) begin
                rf[wr_idx] <= wr_data;
            end
            if (mem_we) begin
                mem[mem_addr] <= rt_val;
            end
        end
    end

endmodule

// File: tb/tb_datapath_core.sv
// Randomised self-checking bench for datapath_core against a behavioural model.
module tb_datapath_core;

    localparam int unsigned M = 32'hFFFF;

    localparam int unsigned C_ADD = 0, C_SLL = 1, C_SRL = 2, C_OR = 3, C_AND = 4;
    localparam int unsigned C_ADDI = 5, C_LI = 6, C_LW = 7, C_SW = 8;
    localparam int unsigned C_MFHI = 13, C_MUL = 14, C_MFLO = 15;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  op_code;
    logic [2:0]  rs_idx, rt_idx, rd_idx;
    logic [3:0]  shamt;
    logic [5:0]  imm;
    logic        sel;
    logic        done;
    logic [15:0] result;
    logic        busy;
    logic [2:0]  dbg_idx;
    logic [15:0] dbg_data;

    logic        instr_ready_s, done_s, busy_s;
    logic [15:0] result_s, dbg_data_s;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned rf_m  [8];
    int unsigned mem_m [16];
    int unsigned hi_m, lo_m;

    datapath_core dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op_code(op_code), .rs_idx(rs_idx), .rt_idx(rt_idx), .rd_idx(rd_idx),
        .shamt(shamt), .imm(imm), .sel(sel), .done(done), .result(result),
        .busy(busy), .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    datapath_core #(.IMM_SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready_s),
        .op_code(op_code), .rs_idx(rs_idx), .rt_idx(rt_idx), .rd_idx(rd_idx),
        .shamt(shamt), .imm(imm), .sel(sel), .done(done_s), .result(result_s),
        .busy(busy_s), .dbg_idx(dbg_idx), .dbg_data(dbg_data_s)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reg(input int unsigned idx, input int unsigned exp, input string tag);
        dbg_idx = 3'(idx);
        #1;
        check_eq(tag, 64'(dbg_data), 64'(exp));
    endtask

    task automatic check_regs();
        for (int i = 0; i < 8; i++) begin
            dbg_idx = 3'(i);
            #1;
            check_eq($sformatf("reg r%0d", i), 64'(dbg_data), 64'(rf_m[i]));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) rf_m[i] = 0;
        for (int i = 0; i < 16; i++) mem_m[i] = 0;
        hi_m = 0;
        lo_m = 0;
    endtask

    // Issue one instruction, update the model, and check the commit.
    // After MUL, an MFHI to rd is left pending so it is stalled during the multiply.
    task automatic issue(input int unsigned op, input int unsigned rs, input int unsigned rt,
                         input int unsigned rd, input int unsigned sh, input int unsigned im,
                         input bit sl);
        int unsigned a, b, ix, addr, res, wait_n, nbusy;
        longint unsigned prod;
        bit ready_bad;
        ix   = im & 63;
        a    = rf_m[rs];
        b    = sl ? ix : rf_m[rt];
        addr = (a + ix) % 16;
        res  = 0;
        case (op)
            C_ADD:  begin res = (a + b) & M;  rf_m[rd] = res; end
            C_SLL:  begin res = (a << sh) & M; rf_m[rd] = res; end
            C_SRL:  begin res = a >> sh;       rf_m[rd] = res; end
            C_OR:   begin res = a | b;         rf_m[rd] = res; end
            C_AND:  begin res = a & b;         rf_m[rd] = res; end
            C_ADDI: begin res = (a + ix) & M;  rf_m[rt] = res; end
            C_LI:   begin res = ix;            rf_m[rt] = res; end
            C_LW:   begin res = mem_m[addr];   rf_m[rt] = res; end
            C_SW:   begin res = rf_m[rt];      mem_m[addr] = res; end
            C_MFHI: begin res = hi_m;          rf_m[rd] = res; end
            C_MFLO: begin res = lo_m;          rf_m[rd] = res; end
            C_MUL:  begin
                prod = 64'(a) * 64'(b);
                hi_m = 32'(prod >> 16) & M;
                lo_m = 32'(prod) & M;
                res  = lo_m;
            end
            default: res = 0;
        endcase
        op_code = 4'(op); rs_idx = 3'(rs); rt_idx = 3'(rt); rd_idx = 3'(rd);
        shamt = 4'(sh); imm = 6'(im); sel = sl; instr_valid = 1'b1;
        wait_n = 0;
        while (!instr_ready && wait_n < 100) begin
            @(posedge clk); #1;
            wait_n++;
        end
        if (wait_n >= 100) check_eq("ready_timeout", 64'(instr_ready), 64'(1));
        @(posedge clk); #1;
        if (op != C_MUL) begin
            instr_valid = 1'b0;
            check_eq($sformatf("done op%0d", op), 64'(done), 64'(1));
            check_eq($sformatf("result op%0d", op), 64'(result), 64'(res));
        end else begin
            op_code = 4'(C_MFHI);
            rd_idx  = 3'(rd);
            nbusy = 0; ready_bad = 0; wait_n = 0;
            while (!done && wait_n < 64) begin
                if (busy) nbusy++;
                if (instr_ready) ready_bad = 1;
                @(posedge clk); #1;
                wait_n++;
            end
            check_eq("mul_busy_cycles", 64'(nbusy), 64'(16));
            check_eq("mul_ready_low", 64'(ready_bad), 64'(0));
            check_eq("mul_done", 64'(done), 64'(1));
            check_eq("mul_result", 64'(result), 64'(res));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int unsigned op, rd, n_done;
        rst = 1'b1; instr_valid = 1'b0; op_code = '0; rs_idx = '0; rt_idx = '0;
        rd_idx = '0; shamt = '0; imm = '0; sel = 1'b0; dbg_idx = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_ready", 64'(instr_ready), 64'(1));
        check_eq("rst_result", 64'(result), 64'(0));
        rst = 1'b0;
        check_regs();

        // Basic ALU sequence
        issue(C_LI, 0, 1, 0, 0, 33, 0);
        issue(C_LI, 0, 2, 0, 0, 34, 0);
        issue(C_ADD, 1, 2, 3, 0, 0, 0);
        check_reg(3, 67, "add_r3");
        issue(C_SLL, 1, 0, 4, 2, 0, 0);
        issue(C_SRL, 4, 0, 5, 3, 0, 0);
        issue(C_OR, 1, 0, 6, 0, 12, 1);
        issue(C_AND, 1, 2, 7, 0, 0, 0);
        check_reg(4, 132, "sll_r4");
        check_reg(5, 16, "srl_r5");
        check_reg(6, 45, "or_r6");
        check_reg(7, 32, "and_r7");

        // Build r1=0x1234, r2=0x0100, multiply, then stalled MFHI
        issue(C_LI, 0, 1, 0, 0, 18, 0);
        issue(C_SLL, 1, 0, 1, 8, 0, 0);
        issue(C_OR, 1, 0, 1, 0, 52, 1);
        issue(C_LI, 0, 2, 0, 0, 1, 0);
        issue(C_SLL, 2, 0, 2, 8, 0, 0);
        issue(C_MUL, 1, 2, 3, 0, 0, 0);
        check_eq("mul_lo_const", 64'(result), 64'(16'h3400));
        issue(C_MFHI, 0, 0, 3, 0, 0, 0);
        check_reg(3, 16'h0012, "mfhi_r3");
        issue(C_MFLO, 0, 0, 4, 0, 0, 0);
        check_reg(4, 16'h3400, "mflo_r4");

        // Memory, including address wrap
        issue(C_LI, 0, 1, 0, 0, 5, 0);
        issue(C_LI, 0, 2, 0, 0, 34, 0);
        issue(C_SW, 1, 2, 0, 0, 9, 0);
        issue(C_LW, 1, 0, 0, 0, 9, 0);
        check_reg(0, 34, "lw_r0");
        issue(C_LI, 0, 1, 0, 0, 10, 0);
        issue(C_LI, 0, 4, 0, 0, 7, 0);
        issue(C_SW, 1, 4, 0, 0, 9, 0);
        issue(C_LI, 0, 1, 0, 0, 3, 0);
        issue(C_LW, 1, 5, 0, 0, 0, 0);
        check_reg(5, 7, "lw_wrap_r5");

        // Immediate extension, both flavours
        issue(C_LI, 0, 1, 0, 0, 10, 0);
        issue(C_ADDI, 1, 2, 0, 0, 63, 0);
        check_reg(2, 73, "addi_zext");
        check_eq("addi_sext", 64'(dbg_data_s), 64'(9));
        check_eq("sext_done", 64'(done_s), 64'(1));
        check_eq("sext_result", 64'(result_s), 64'(9));
        check_eq("sext_idle", 64'({instr_ready_s, busy_s}), 64'(2'b10));
        check_regs();

        // Random instruction stream
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 15);
            rd = $urandom_range(0, 7);
            issue(op, $urandom_range(0, 7), $urandom_range(0, 7), rd,
                  $urandom_range(0, 15), $urandom_range(0, 63), 1'($urandom_range(0, 1)));
            if (op == C_MUL) issue(C_MFHI, 0, 0, rd, 0, 0, 0);
            if (n % 10 == 9) check_regs();
        end

        // Reset on the fifth cycle of a multiply
        issue(C_LI, 0, 1, 0, 0, 63, 0);
        op_code = 4'(C_MUL); rs_idx = 3'd1; rt_idx = 3'd1; sel = 1'b0; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check_eq("mid_mul_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_eq("abort_busy", 64'(busy), 64'(0));
        check_eq("abort_ready", 64'(instr_ready), 64'(1));
        check_eq("abort_done", 64'(done), 64'(0));
        check_eq("abort_result", 64'(result), 64'(0));
        check_regs();
        n_done = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check_eq("abort_no_done", 64'(n_done), 64'(0));
        issue(C_MFHI, 0, 0, 1, 0, 0, 0);
        issue(C_MFLO, 0, 0, 2, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
